// File: rtl/d3s_sched_pkg.sv
// Shared types and constants for the DDS sample scheduler.
// Imported by the scheduler top and its PPS/tick sub-module.
package d3s_sched_pkg;

    localparam int unsigned c_D3S_TAI_W = 40;
    localparam int unsigned c_D3S_OVF_W = 16;

    localparam logic [c_D3S_OVF_W-1:0] c_D3S_OVF_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        ERR
    } t_d3s_sched_state;

    typedef struct packed {
        logic [c_D3S_TAI_W-1:0] tai;
        logic [27:0]            ticks;
        logic [15:0]            seq;
    } t_d3s_stamp;

endpackage

// File: rtl/d3s_pps_tick_gen.sv
// Detects White Rabbit second boundaries from TAI changes and
// counts clk_sys ticks since the last boundary.
module d3s_pps_tick_gen
    import d3s_sched_pkg::*;
#(
    parameter int g_ticks_width = 28
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_i,
    input  logic [c_D3S_TAI_W-1:0]   tm_tai_i,
    output logic [c_D3S_TAI_W-1:0]   tai_q,
    output logic                     pps_tick,
    output logic [g_ticks_width-1:0] ticks_q
);

    logic tai_loaded;

    // tai_q is meaningless until its first load, so no tick before that
    assign pps_tick = (tm_tai_i != tai_q) & tai_loaded;

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            tai_q      <= '0;
            tai_loaded <= 1'b0;
            ticks_q    <= '0;
        end else begin
            tai_q      <= tm_tai_i;
            tai_loaded <= 1'b1;
            if (pps_tick)
                ticks_q <= '0;
            else if (!(&ticks_q))
                ticks_q <= ticks_q + 1'b1;
        end
    end

endmodule

// File: rtl/d3s_sample_scheduler.sv
// Aligns DDS phase sampling to a WR second boundary, strobes at the
// programmed rate and hands out timestamped samples over valid/ready.
module d3s_sample_scheduler
    import d3s_sched_pkg::*;
#(
    parameter int g_prescaler_width = 16,
    parameter int g_ticks_width     = 28,
    parameter int g_seq_width       = 16
) (
    input  logic                         clk_sys_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [g_prescaler_width-1:0] prescaler_i,
    input  logic                         tm_link_up_i,
    input  logic                         tm_time_valid_i,
    input  logic [c_D3S_TAI_W-1:0]       tm_tai_i,
    output logic                         sample_p_o,
    output logic                         stamp_valid_o,
    input  logic                         stamp_ready_i,
    output logic [c_D3S_TAI_W-1:0]       stamp_tai_o,
    output logic [g_ticks_width-1:0]     stamp_ticks_o,
    output logic [g_seq_width-1:0]       stamp_seq_o,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [c_D3S_OVF_W-1:0]       ovf_cnt_o
);

    t_d3s_sched_state state_q, state_d;

    logic [c_D3S_TAI_W-1:0]       tai_q;
    logic [g_ticks_width-1:0]     ticks_q;
    logic                         pps_tick;
    logic [g_prescaler_width-1:0] presc_q;
    logic [g_prescaler_width-1:0] div_q;
    logic [g_seq_width-1:0]       seq_q;
    logic                         strobe_d;
    logic                         arm_go;
    logic                         link_ok;

    d3s_pps_tick_gen #(
        .g_ticks_width (g_ticks_width)
    ) u_pps (
        .clk_sys_i (clk_sys_i),
        .rst_i     (rst_i),
        .tm_tai_i  (tm_tai_i),
        .tai_q     (tai_q),
        .pps_tick  (pps_tick),
        .ticks_q   (ticks_q)
    );

    assign link_ok = tm_link_up_i & tm_time_valid_i;

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        arm_go   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && link_ok) begin
                    state_d = ARM;
                    arm_go  = 1'b1;
                end
            end
            ARM: begin
                if (pps_tick) begin
                    state_d  = RUN;
                    strobe_d = 1'b1;
                end
            end
            RUN:     strobe_d = (div_q == presc_q);
            ERR:     state_d  = ERR;
            default: state_d  = IDLE;
        endcase
        // disable wins over timing loss
        if (!enable_i) begin
            state_d  = IDLE;
            strobe_d = 1'b0;
            arm_go   = 1'b0;
        end else if ((state_q == ARM || state_q == RUN) && !link_ok) begin
            state_d  = ERR;
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            div_q   <= '0;
        end else begin
            if (arm_go)
                presc_q <= prescaler_i;
            if (strobe_d || state_d != RUN)
                div_q <= '0;
            else
                div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            sample_p_o    <= 1'b0;
            busy_o        <= 1'b0;
            err_o         <= 1'b0;
            seq_q         <= '0;
            stamp_valid_o <= 1'b0;
            stamp_tai_o   <= '0;
            stamp_ticks_o <= '0;
            stamp_seq_o   <= '0;
        end else begin
            sample_p_o <= strobe_d;
            busy_o     <= (state_d == ARM) || (state_d == RUN);
            err_o      <= (state_d == ERR);
            if (state_d == IDLE) begin
                seq_q         <= '0;
                stamp_valid_o <= 1'b0;
                stamp_tai_o   <= '0;
                stamp_ticks_o <= '0;
                stamp_seq_o   <= '0;
            end else if (sample_p_o) begin
                seq_q <= seq_q + 1'b1;
                if (!stamp_valid_o || stamp_ready_i) begin
                    stamp_valid_o <= 1'b1;
                    stamp_tai_o   <= tai_q;
                    stamp_ticks_o <= ticks_q;
                    stamp_seq_o   <= seq_q;
                end
            end else if (stamp_ready_i) begin
                stamp_valid_o <= 1'b0;
            end
        end
    end

    // a strobe that finds the slot still occupied loses its stamp
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i)
            ovf_cnt_o <= '0;
        else if (arm_go)
            ovf_cnt_o <= '0;
        else if (sample_p_o && stamp_valid_o && !stamp_ready_i
                 && ovf_cnt_o != c_D3S_OVF_MAX)
            ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end

endmodule

// File: doc/d3s_sample_scheduler.md
# d3s_sample_scheduler

Sequences DDS phase sampling for the distributed DDS core. It aligns the start of sampling to a White Rabbit second boundary and generates a sample strobe at the programmed prescaler rate. Each sample is timestamped (TAI, tick-in-second, sequence number) and the stamp is handed to a downstream FIFO over a valid/ready handshake. It sits between the DDS CSR block (CR enable/prescaler fields) and the ADC/phase-sampling datapath.

## Interface
Parameters:
- g_prescaler_width, 16, width of prescaler_i.
- g_ticks_width, 28, width of the tick-in-second counter and stamp.
- g_seq_width, 16, width of the sample sequence number.

Ports:
- clk_sys_i  in  1  system clock; all inputs are synchronous to it.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  CR.ENABLE; level.
- prescaler_i  in  g_prescaler_width  CR.PRESC; sample period = prescaler_i+1 cycles.
- tm_link_up_i  in  1  WR link up.
- tm_time_valid_i  in  1  WR time valid.
- tm_tai_i  in  40  WR TAI seconds.
- sample_p_o  out  1  one-cycle sample strobe to datapath.
- stamp_valid_o  out  1  stamp available.
- stamp_ready_i  in  1  downstream accepts stamp.
- stamp_tai_o  out  40  TAI of sample.
- stamp_ticks_o  out  g_ticks_width  clk_sys ticks since second boundary.
- stamp_seq_o  out  g_seq_width  sample sequence number.
- busy_o  out  1  state is ARM or RUN.
- err_o  out  1  sticky timing-loss error.
- ovf_cnt_o  out  16  dropped-stamp counter, saturating.

## Operation
- PPS detection: tai_q registers tm_tai_i every cycle. pps_tick = (tm_tai_i != tai_q) & tai_loaded. tai_loaded is set one cycle after reset and suppresses a spurious tick at startup.
- Tick counter: becomes 0 in the cycle after pps_tick. Otherwise it increments, saturating at all-ones.
- States:
  - IDLE: no strobes; sequence number is 0; stamp output is cleared. Goes to ARM when enable_i & tm_link_up_i & tm_time_valid_i. presc_q latches prescaler_i on this transition.
  - ARM: waits for pps_tick, then goes to RUN.
  - RUN: first strobe comes in the cycle after the pps_tick detection cycle. Subsequent strobes follow every presc_q+1 cycles. prescaler_i = 0 gives a strobe every cycle. Later pps_ticks do not resync the divider. Changes to prescaler_i while running are ignored until the next IDLE→ARM.
  - ERR: entered from ARM/RUN when tm_link_up_i or tm_time_valid_i drops; err_o=1; no strobes. Goes to IDLE when enable_i=0.
- enable_i=0 in any state returns to IDLE in the next cycle. It is checked before the error condition, and no strobe is issued in the cycle that state is entered. err_o clears on entering IDLE.
- Stamp: in a strobe cycle the stamp is {tai_q, tick counter, seq}, and seq then increments (wraps).
  - If stamp_valid_o=0, or stamp_ready_i=1 in the same cycle, the stamp loads and stamp_valid_o=1 next cycle.
  - If stamp_valid_o=1 and stamp_ready_i=0, the new stamp is dropped and ovf_cnt_o increments (saturating at 0xFFFF). sample_p_o is still issued and seq still increments.
- stamp_valid_o clears on ready without a new strobe, and on entering IDLE. ovf_cnt_o clears only on reset or on the IDLE→ARM transition.

## Timing
- Reset values: all outputs 0, state IDLE, tai_loaded 0.
- pps_tick detection cycle n → RUN entered at n+1 with sample_p_o=1 at n+1; stamp_ticks_o=0, stamp_valid_o=1 at n+2.
- Strobe k (k≥0) occurs at n+1+k·(P+1) with ticks k·(P+1) (mod second rollover).
- Stamp latency is one cycle after sample_p_o. Outputs are registered.

## Structure
- Package d3s_sched_pkg holds:
  - t_d3s_sched_state enum {IDLE, ARM, RUN, ERR};
  - t_d3s_stamp record {tai, ticks, seq};
  - c_D3S_OVF_MAX constant.
- Sub-module d3s_pps_tick_gen: tai_q, tai_loaded, pps_tick, tick counter.

## Test plan
In all scenarios the bench increments tm_tai_i every 500 clk_sys cycles starting at 100.
- Enable with prescaler 20 mid-second → ARM; first sample_p_o exactly 1 cycle after the TAI 100→101 detection, stamp {101, 0, 0}; next stamps {101, 21, 1} and {101, 42, 2}; spacing 21 cycles.
- prescaler 0, ready tied high → strobe every cycle; seq 0,1,2… with no gaps; ovf_cnt_o=0.
- ready held low for 10 strobes (prescaler 3) → first stamp held unchanged; ovf_cnt_o=9; sample_p_o unaffected; on ready the held stamp (seq 0) is accepted.
- Drop tm_time_valid_i in RUN → err_o=1 next cycle, no strobes. Drop enable_i → IDLE, err_o=0. Re-enable → waits for next PPS, seq restarts at 0.
- Change prescaler_i from 20 to 5 while in RUN → spacing stays 21. After disable/re-enable the spacing is 6.
- Assert rst_i asynchronously mid-RUN with stamp_valid_o=1 → all outputs 0 immediately; no strobe until the next enable plus PPS, and no spurious PPS in the first post-reset cycle.
